// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state encoding and counter-width helper for serial_adder
package serial_adder_pkg;
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] DONE = 2'b10;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) r = ((1 << i) < n) ? i + 1 : r;
        return r;
    endfunction
endpackage

// File: rtl/serial_adder_full_adder.sv
// serial_adder_full_adder: one-bit full adder built from two half adders plus carry OR
module half_adder (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module full_adder (
    output logic s,
    output logic c,
    input  logic a,
    input  logic b,
    input  logic cin
);
    logic s0, c0, c1;
    half_adder h0 (.s(s0), .c(c0), .a(a), .b(b));
    half_adder h1 (.s(s), .c(c1), .a(s0), .b(cin));
    assign c = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder; SERIAL_ADDER_SUB_EN adds a sub port for a-b
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    logic [1:0] state;
    logic [WIDTH-1:0] areg, breg, wreg, next_w;
    logic [CW-1:0] cnt;
    logic carry, s_bit, c_bit, accept, sub_en;
`ifdef SERIAL_ADDER_SUB_EN
    assign sub_en = sub;
`else
    assign sub_en = 1'b0;
`endif
    full_adder fa (.s(s_bit), .c(c_bit), .a(areg[0]), .b(breg[0]), .cin(carry));
    assign accept = start && (state == IDLE || state == DONE);
    assign next_w = {s_bit, wreg[WIDTH-1:1]};
    assign busy   = state == RUN;
    assign done   = state == DONE;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            areg  <= '0;
            breg  <= '0;
            wreg  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            areg  <= a;
            breg  <= sub_en ? ~b : b;
            carry <= sub_en;
            cnt   <= '0;
            state <= RUN;
        end else if (state == RUN) begin
            areg  <= areg >> 1;
            breg  <= breg >> 1;
            wreg  <= next_w;
            carry <= c_bit;
            // result is published only on the last bit, so sum never shows partial values
            if (cnt == LAST) begin
                sum   <= next_w;
                cout  <= c_bit;
                state <= DONE;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (state == DONE) begin
            state <= IDLE;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed plus random checks of serial_adder against an arithmetic model
module tb_serial_adder;
    localparam int WIDTH = 8;
    logic clk = 1'b0;
    logic rst_n, start, busy, done, cout;
    logic [7:0] a, b, sum;
`ifdef SERIAL_ADDER_SUB_EN
    logic sub;
`endif
    int checks = 0;
    int fails = 0;
    logic [7:0] exp_sum, prev_sum;
    logic exp_cout, prev_cout;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a(a),
        .b(b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy),
        .done(done),
        .sum(sum),
        .cout(cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [7:0] x, input logic [7:0] y, input logic s);
        int r;
        r = s ? int'(x) + 256 - int'(y) : int'(x) + int'(y);
        exp_sum  = r[7:0];
        exp_cout = r[8];
        a = x;
        b = y;
`ifdef SERIAL_ADDER_SUB_EN
        sub = s;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_op(input int poke);
        for (int k = 0; k < WIDTH; k++) begin
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            check("sum_hold", sum, prev_sum);
            check("cout_hold", cout, prev_cout);
            if (k == poke) begin
                a = 8'h10;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_pulse", done, 1);
        check("busy_end", busy, 0);
        check("sum", sum, exp_sum);
        check("cout", cout, exp_cout);
        prev_sum  = exp_sum;
        prev_cout = exp_cout;
    endtask

    task automatic idle_gap();
        @(negedge clk);
        check("done_idle", done, 0);
        check("busy_idle", busy, 0);
        check("sum_idle", sum, prev_sum);
        check("cout_idle", cout, prev_cout);
    endtask

    initial begin
        logic s;
        rst_n = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        prev_sum  = '0;
        prev_cout = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_gap();

        launch(8'h03, 8'h05, 1'b0);
        finish_op(-1);
        idle_gap();

        launch(8'hFF, 8'h01, 1'b0);
        finish_op(-1);
        idle_gap();
        idle_gap();

        launch(8'h22, 8'h11, 1'b0);
        finish_op(2);
        idle_gap();
        idle_gap();

        launch(8'h12, 8'h34, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        prev_sum  = '0;
        prev_cout = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) idle_gap();

        launch(8'h01, 8'h02, 1'b0);
        finish_op(-1);
        launch(8'h80, 8'h80, 1'b0);
        finish_op(-1);
        idle_gap();

`ifdef SERIAL_ADDER_SUB_EN
        launch(8'h05, 8'h03, 1'b1);
        finish_op(-1);
        launch(8'h03, 8'h05, 1'b1);
        finish_op(-1);
        idle_gap();
`endif

        for (int n = 0; n < 24; n++) begin
`ifdef SERIAL_ADDER_SUB_EN
            s = 1'($urandom_range(0, 1));
`else
            s = 1'b0;
`endif
            launch(8'($urandom), 8'($urandom), s);
            finish_op(-1);
            if ($urandom_range(0, 1) == 1) idle_gap();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
